uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default ceres_param::UART_DATA_WIDTH (8), the width of a received data word.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default ceres_param::UART_RX_FIFO_DEPTH, the number of receive buffer entries.
REQ-003 Port clk_i, input, 1 bit: the single clock.
REQ-004 Port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port baud_div_i, input, 16 bits: clk_i cycles per bit period.
REQ-006 Port rx_en_i, input, 1 bit: receiver enable.
REQ-007 Port rx_bit_i, input, 1 bit: asynchronous serial line, idle high.
REQ-008 Port rx_re_i, input, 1 bit: pop the head buffer entry.
REQ-009 Port err_clr_i, input, 1 bit: clear the sticky error flags.
REQ-010 Port dout_o, output, 8 bits: head buffer entry.
REQ-011 Port full_o, output, 1 bit: receive buffer full.
REQ-012 Port empty_o, output, 1 bit: receive buffer empty.
REQ-013 Port frame_err_o, output, 1 bit: sticky flag, stop bit sampled low.
REQ-014 Port overrun_o, output, 1 bit: sticky flag, byte dropped because the buffer was full.

Function
REQ-015 rx_bit_i SHALL pass through a 2-flop synchronizer, reset value 1; all decisions use the synchronized value rxs.
REQ-016 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-017 The FSM states SHALL be IDLE, START, DATA and STOP.
REQ-018 IDLE -> START SHALL occur on a 1-to-0 transition of rxs while rx_en_i=1 and baud_div_i>=2; the baud counter clears on this transition.
REQ-019 In START, at count (baud_div_i>>1)-1, rxs=0 SHALL go to DATA and rxs=1 SHALL go to IDLE (glitch rejection); the counter clears at this point.
REQ-020 In DATA, each time the counter reaches baud_div_i-1, the block SHALL shift in rxs, clear the counter and increment a 3-bit bit index; after index 7 it SHALL go to STOP.
REQ-021 In STOP, at count baud_div_i-1, the block SHALL sample rxs: 1 pushes the byte if full_o=0, otherwise sets overrun_o; 0 sets frame_err_o and discards the byte. The next state is IDLE in both cases.
REQ-022 A push SHALL be a single-cycle write; empty_o SHALL fall the cycle after the stop sample.
REQ-023 rx_re_i SHALL be ignored when empty_o=1; dout_o SHALL be valid whenever empty_o=0 (first-word fall-through).
REQ-024 A simultaneous pop and push on a full buffer SHALL treat the push as overrun; the full decision uses full_o of that cycle.
REQ-025 rx_en_i=0 in any state SHALL abort to IDLE the next cycle, with no push and no error flag change.
REQ-026 baud_div_i<2 SHALL hold the FSM in IDLE; a baud_div_i change mid-frame is unsupported.
REQ-027 err_clr_i SHALL clear both flags; a set event in the same cycle SHALL win.
REQ-028 The counter SHALL be 16 bits, compared against baud_div_i-1 in 16-bit arithmetic, and SHALL never wrap within a frame.

Reset
REQ-029 rst_ni=0 SHALL asynchronously force IDLE, counter 0, bit index 0, synchronizer 1, buffer empty (empty_o=1, full_o=0), frame_err_o=0, overrun_o=0 and dout_o=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial byte; after release the block SHALL wait for a new falling edge.

Structure
REQ-031 The FSM state enum and the UART_RX_FIFO_DEPTH constant SHALL live in ceres_param.
REQ-032 The buffer SHALL be one wbit_fifo instance with reset driven by !rst_ni; no other sub-modules.

Verification
REQ-033 baud_div_i=16, rx_en_i=1, frame 0xA5 -> dout_o=0xA5, empty_o falls within 9.5*16+4 cycles of the start edge, and both error flags stay 0.
REQ-034 A 5-cycle low glitch with baud_div_i=16 -> no push, FSM returns to IDLE, and the next valid frame 0x3C is received correctly.
REQ-035 Frame 0x55 with the stop bit held low -> frame_err_o=1, buffer stays empty; err_clr_i pulse -> frame_err_o=0.
REQ-036 FIFO_DEPTH+1 frames with no pops -> full_o=1, overrun_o=1, and pops return the first FIFO_DEPTH bytes in order.
REQ-037 rst_ni pulsed low during data bit 4 -> all outputs return to reset values immediately; the next frame 0xFF is received correctly.
REQ-038 rx_en_i dropped mid-frame and then restored -> the partial byte is not pushed and flags are unchanged; the next frame 0x81 is received correctly.

Source files
------------

// File: rtl/ceres_param.sv
// Shared constants and types for the Ceres UART receive path.
package ceres_param;

    localparam int unsigned UART_DATA_WIDTH    = 8;
    localparam int unsigned UART_RX_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_e;

endpackage

// File: rtl/wbit_fifo.sv
// Synchronous first-word fall-through FIFO with asynchronous active-high reset.
module wbit_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);
    assign do_wr   = wr_en_i && !full_o;
    assign do_rd   = rd_en_i && !empty_o;
    // Head is forced to zero while empty so the output has a defined reset value.
    assign rdata_o = empty_o ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, sticky error flags, receive FIFO.
module uart_rx
    import ceres_param::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = UART_RX_FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [15:0]           baud_div_i,
    input  logic                  rx_en_i,
    input  logic                  rx_bit_i,
    input  logic                  rx_re_i,
    input  logic                  err_clr_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  frame_err_o,
    output logic                  overrun_o
);

    uart_rx_state_e        state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  sync_q, rxs, rxs_q;
    logic                  push, fe_set, ov_set;
    logic [15:0]           baud_m1, half_m1;
    logic                  fall;

    assign baud_m1 = baud_div_i - 16'd1;
    assign half_m1 = (baud_div_i >> 1) - 16'd1;
    assign fall    = rxs_q && !rxs;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 1'b1;
            rxs    <= 1'b1;
            rxs_q  <= 1'b1;
        end else begin
            sync_q <= rx_bit_i;
            rxs    <= sync_q;
            rxs_q  <= rxs;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        push    = 1'b0;
        fe_set  = 1'b0;
        ov_set  = 1'b0;
        if (!rx_en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (fall && baud_div_i >= 16'd2) begin
                        state_d = START;
                    end
                end
                START: begin
                    if (cnt_q == half_m1) begin
                        cnt_d   = '0;
                        state_d = rxs ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt_q == baud_m1) begin
                        cnt_d   = '0;
                        shreg_d = {rxs, shreg_q[DATA_WIDTH-1:1]};
                        idx_d   = idx_q + 3'd1;
                        if (idx_q == 3'(DATA_WIDTH - 1)) begin
                            state_d = STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt_q == baud_m1) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        if (!rxs) begin
                            fe_set = 1'b1;
                        end else if (full_o) begin
                            ov_set = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A set event in the same cycle as err_clr_i takes priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (fe_set) begin
                frame_err_o <= 1'b1;
            end else if (err_clr_i) begin
                frame_err_o <= 1'b0;
            end
            if (ov_set) begin
                overrun_o <= 1'b1;
            end else if (err_clr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

    wbit_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (!rst_ni),
        .wr_en_i (push),
        .wdata_i (shreg_q),
        .rd_en_i (rx_re_i),
        .rdata_o (dout_o),
        .full_o  (full_o),
        .empty_o (empty_o)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames in, monitor pops and compares received bytes.
module tb_uart_rx;
    import ceres_param::*;

    localparam int unsigned BAUD  = 16;
    localparam int unsigned DEPTH = UART_RX_FIFO_DEPTH;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_div;
    logic        rx_en;
    logic        rx_bit;
    logic        rx_re = 1'b0;
    logic        err_clr;
    logic [7:0]  dout;
    logic        full, empty, frame_err, overrun;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q[$];
    bit          auto_pop = 1'b0;

    uart_rx #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .baud_div_i  (baud_div),
        .rx_en_i     (rx_en),
        .rx_bit_i    (rx_bit),
        .rx_re_i     (rx_re),
        .err_clr_i   (err_clr),
        .dout_o      (dout),
        .full_o      (full),
        .empty_o     (empty),
        .frame_err_o (frame_err),
        .overrun_o   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: whenever popping is allowed and a byte is present, compare against the queue head.
    always @(negedge clk) begin
        rx_re = 1'b0;
        if (auto_pop && rst_n && !empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h expected none", dout);
            end else begin
                check("rx_byte", {24'd0, dout}, {24'd0, exp_q.pop_front()});
            end
            rx_re = 1'b1;
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx_bit = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_bit = b[i];
            repeat (BAUD) @(negedge clk);
        end
        rx_bit = stop_bit;
        repeat (BAUD) @(negedge clk);
        rx_bit = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && empty) begin
                done = 1'b1;
                break;
            end
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;

        rst_n    = 1'b0;
        rx_bit   = 1'b1;
        rx_en    = 1'b1;
        baud_div = 16'(BAUD);
        err_clr  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_dout", {24'd0, dout}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic frame with latency bound from the start edge.
        auto_pop = 1'b1;
        exp_q.push_back(8'hA5);
        n    = 0;
        seen = 1'b0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(negedge clk);
                for (int i = 0; i < 200; i++) begin
                    @(posedge clk);
                    #1;
                    n++;
                    if (!empty) begin
                        seen = 1'b1;
                        break;
                    end
                end
            end
        join
        check("a5_latency_ok", {31'd0, seen && (n <= 156)}, 32'd1);
        check("a5_frame_err", {31'd0, frame_err}, 32'd0);
        check("a5_overrun", {31'd0, overrun}, 32'd0);
        wait_drain("a5_drain");

        // Short low glitch is rejected, then a real frame.
        @(negedge clk);
        rx_bit = 1'b0;
        repeat (5) @(negedge clk);
        rx_bit = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
        check("glitch_empty", {31'd0, empty}, 32'd1);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        wait_drain("3c_drain");

        // Stop bit low: frame error, nothing buffered, then clear.
        send_frame(8'h55, 1'b0);
        check("fe_set", {31'd0, frame_err}, 32'd1);
        check("fe_empty", {31'd0, empty}, 32'd1);
        check("fe_no_overrun", {31'd0, overrun}, 32'd0);
        pulse_err_clr();
        #1;
        check("fe_cleared", {31'd0, frame_err}, 32'd0);

        // Overflow: DEPTH+1 frames with no pops.
        auto_pop = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            logic [7:0] b;
            b = 8'(8'h11 * (i + 1));
            if (i < DEPTH) exp_q.push_back(b);
            send_frame(b, 1'b1);
        end
        check("ovr_full", {31'd0, full}, 32'd1);
        check("ovr_overrun", {31'd0, overrun}, 32'd1);
        check("ovr_frame_err", {31'd0, frame_err}, 32'd0);
        auto_pop = 1'b1;
        wait_drain("ovr_drain");
        check("ovr_not_full", {31'd0, full}, 32'd0);
        pulse_err_clr();
        #1;
        check("ovr_cleared", {31'd0, overrun}, 32'd0);

        // Async reset mid data bit 4 with a byte buffered and frame_err set.
        auto_pop = 1'b0;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        send_frame(8'h55, 1'b0);
        check("pre_rst_not_empty", {31'd0, empty}, 32'd0);
        check("pre_rst_fe", {31'd0, frame_err}, 32'd1);
        @(negedge clk);
        rx_bit = 1'b0;
        repeat (BAUD * 5 + BAUD / 2) @(negedge clk);
        #2;
        rst_n  = 1'b0;
        rx_bit = 1'b1;
        #1;
        check("mid_rst_empty", {31'd0, empty}, 32'd1);
        check("mid_rst_full", {31'd0, full}, 32'd0);
        check("mid_rst_fe", {31'd0, frame_err}, 32'd0);
        check("mid_rst_ovr", {31'd0, overrun}, 32'd0);
        check("mid_rst_dout", {24'd0, dout}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * BAUD) @(negedge clk);
        check("post_rst_empty", {31'd0, empty}, 32'd1);
        auto_pop = 1'b1;
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1);
        wait_drain("ff_drain");

        // Enable dropped mid-frame: no push, flags untouched.
        send_frame(8'h00, 1'b0);
        check("en_pre_fe", {31'd0, frame_err}, 32'd1);
        @(negedge clk);
        rx_bit = 1'b0;
        repeat (BAUD * 4) @(negedge clk);
        rx_en  = 1'b0;
        rx_bit = 1'b1;
        repeat (3) @(negedge clk);
        rx_en = 1'b1;
        repeat (12 * BAUD) @(negedge clk);
        check("en_abort_empty", {31'd0, empty}, 32'd1);
        check("en_abort_fe", {31'd0, frame_err}, 32'd1);
        check("en_abort_ovr", {31'd0, overrun}, 32'd0);
        pulse_err_clr();
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        wait_drain("81_drain");
        check("final_fe", {31'd0, frame_err}, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
